// File: rtl/craps_round_ctrl.sv
// -----------------------------------------------------------------------------
// craps_round_ctrl
//
// Round sequencer for the craps datapath. A rising edge on the debounced roll
// button starts a roll: the dice roller tumbles for ROLL_CYCLES clocks, the
// dice are then frozen and shown (disp_en held high through the evaluation
// cycle), and the roll is scored with come-out / point-phase craps rules.
//
// Handshake: there is no valid/ready pair. roll_btn is a level. Only its
// rising edge is a request, and only in COME_OUT, POINT, WIN or LOSE. A rise
// seen while busy is dropped, not queued.
//
// Optional build macro: CRAPS_ROLL_COUNT_EN adds the roll_count output, which
// counts legal evaluations, saturates at 255 and clears on reset or when a new
// round starts.
//
// Ports
//   clock       system clock, rising edge
//   resetn      asynchronous active-low reset
//   roll_btn    debounced synchronous roll request level
//   dice1/dice2 die faces from the roller, legal 1..6
//   roll_en     roller tumble enable, high exactly ROLL_CYCLES clocks per roll
//   disp_en     clock_en for the Display block (ROLLING and EVAL)
//   point       established point, 0 when none
//   win/lose    round result, held until the next round starts
//   busy        high in ROLLING or EVAL
//   roll_count  legal evaluations (CRAPS_ROLL_COUNT_EN builds only)
//   state_dbg   current FSM state, for debug and checker binding
// -----------------------------------------------------------------------------
module craps_round_ctrl #(
   parameter int ROLL_CYCLES = 16
) (
   input  logic       clock,
   input  logic       resetn,
   input  logic       roll_btn,
   input  logic [2:0] dice1,
   input  logic [2:0] dice2,
   output logic       roll_en,
   output logic       disp_en,
   output logic [3:0] point,
   output logic       win,
   output logic       lose,
   output logic       busy,
`ifdef CRAPS_ROLL_COUNT_EN
   output logic [7:0] roll_count,
`endif
   output logic [2:0] state_dbg
);

   typedef enum logic [2:0] {
      S_COME_OUT = 3'd0,
      S_POINT    = 3'd1,
      S_ROLLING  = 3'd2,
      S_EVAL     = 3'd3,
      S_WIN      = 3'd4,
      S_LOSE     = 3'd5
   } state_t;

   // Counter wide enough for ROLL_CYCLES-1. A single bit covers ROLL_CYCLES == 1.
   localparam int            CW         = (ROLL_CYCLES > 1) ? $clog2(ROLL_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_RELOAD = CW'(ROLL_CYCLES - 1);

   state_t        state;
   logic          from_point;   // phase of the roll in progress: 1 = point phase
   logic [CW-1:0] cnt;
   logic          roll_btn_q;
   logic          roll_rise;
   logic          dice_legal;
   logic [3:0]    sum;

   assign roll_rise  = roll_btn & ~roll_btn_q;
   assign dice_legal = (dice1 != 3'd0) && (dice1 != 3'd7) &&
                       (dice2 != 3'd0) && (dice2 != 3'd7);
   assign sum        = {1'b0, dice1} + {1'b0, dice2};
   assign state_dbg  = state;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state      <= S_COME_OUT;
         from_point <= 1'b0;
         cnt        <= '0;
         roll_btn_q <= 1'b0;
         roll_en    <= 1'b0;
         disp_en    <= 1'b0;
         point      <= 4'd0;
         win        <= 1'b0;
         lose       <= 1'b0;
         busy       <= 1'b0;
`ifdef CRAPS_ROLL_COUNT_EN
         roll_count <= 8'd0;
`endif
      end else begin
         roll_btn_q <= roll_btn;
         case (state)
            S_COME_OUT, S_POINT: begin
               if (roll_rise) begin
                  state      <= S_ROLLING;
                  from_point <= (state == S_POINT);
                  cnt        <= CNT_RELOAD;
                  roll_en    <= 1'b1;
                  disp_en    <= 1'b1;
                  busy       <= 1'b1;
               end
            end

            S_ROLLING: begin
               if (cnt == '0) begin
                  state   <= S_EVAL;
                  roll_en <= 1'b0;   // dice freeze, display stays on
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end

            S_EVAL: begin
               if (!dice_legal) begin
                  // Bad face from the roller: tumble again, phase and score kept.
                  state   <= S_ROLLING;
                  cnt     <= CNT_RELOAD;
                  roll_en <= 1'b1;
               end else begin
                  disp_en <= 1'b0;
                  busy    <= 1'b0;
`ifdef CRAPS_ROLL_COUNT_EN
                  if (roll_count != 8'hFF) roll_count <= roll_count + 8'd1;
`endif
                  if (!from_point) begin
                     case (sum)
                        4'd7, 4'd11: begin
                           state <= S_WIN;
                           win   <= 1'b1;
                        end
                        4'd2, 4'd3, 4'd12: begin
                           state <= S_LOSE;
                           lose  <= 1'b1;
                        end
                        default: begin
                           state <= S_POINT;
                           point <= sum;
                        end
                     endcase
                  end else if (sum == point) begin
                     state <= S_WIN;
                     win   <= 1'b1;
                  end else if (sum == 4'd7) begin
                     state <= S_LOSE;
                     lose  <= 1'b1;
                  end else begin
                     state <= S_POINT;
                  end
               end
            end

            S_WIN, S_LOSE: begin
               // A press here only starts a fresh round; rolling needs another press.
               if (roll_rise) begin
                  state <= S_COME_OUT;
                  win   <= 1'b0;
                  lose  <= 1'b0;
                  point <= 4'd0;
`ifdef CRAPS_ROLL_COUNT_EN
                  roll_count <= 8'd0;
`endif
               end
            end

            default: state <= S_COME_OUT;
         endcase
      end
   end

endmodule

// File: doc/craps_round_ctrl.md
Name: craps_round_ctrl

Overview:
- Game sequencer for the craps datapath.
- On a player roll request it enables the dice roller for a fixed tumble period, then freezes the dice, holds the seven-segment display enable high so the final faces are shown, and scores the roll.
- Scoring follows craps rules: come-out roll, point phase, win/lose.
- Sits between the debounced roll button, the dice roller (dice1/dice2 source) and the Display block (drives its clock_en).

Parameters:
- ROLL_CYCLES, 16, number of clock cycles roll_en stays high per roll (minimum 1).

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- roll_btn  input  1  debounced, synchronous roll request level; a roll starts on its rising edge.
- dice1  input  3  die 1 face from roller; legal values 1..6.
- dice2  input  3  die 2 face from roller; legal values 1..6.
- roll_en  output  1  enables dice roller tumbling.
- disp_en  output  1  clock_en to Display.
- point  output  4  established point (0 = none).
- win  output  1  round won; held until next round.
- lose  output  1  round lost; held until next round.
- busy  output  1  high in ROLLING or EVAL.

Behaviour:
- All outputs registered.
- Reset (async, resetn=0): state=COME_OUT, roll_en=0, disp_en=0, point=0, win=0, lose=0, busy=0, tumble counter=0, edge register=0.
- Edge detect: roll_rise = roll_btn & ~roll_btn_q, where roll_btn_q is roll_btn registered one cycle.
- States: COME_OUT, POINT, ROLLING, EVAL, WIN, LOSE. A phase flag records whether ROLLING was entered from COME_OUT or from POINT.
- COME_OUT/POINT + roll_rise:
  - Next cycle enters ROLLING: counter=ROLL_CYCLES-1, roll_en=1, disp_en=1, busy=1.
- ROLLING:
  - Counter decrements each cycle.
  - At counter==0, next state is EVAL: roll_en=0, disp_en stays 1.
  - roll_en is therefore high for exactly ROLL_CYCLES cycles.
- EVAL (exactly 1 cycle):
  - disp_en=1 so Display captures the frozen dice; busy=1.
  - sum = dice1 + dice2, computed at 4 bits (range 2..12).
  - Illegal die (0 or 7 on either input): re-enter ROLLING with counter reloaded; score unchanged; phase preserved.
  - Come-out phase: sum 7 or 11 -> WIN; sum 2, 3 or 12 -> LOSE; otherwise point=sum -> POINT.
  - Point phase: sum==point -> WIN; sum==7 -> LOSE; otherwise -> POINT (point unchanged).
- Leaving EVAL: disp_en=0, busy=0.
- WIN/LOSE: win or lose held high, point held.
  - roll_rise here clears win, lose and point and goes to COME_OUT next cycle. It does not roll; a further press is needed to roll.
- roll_rise while busy is ignored (no queueing).
- Holding roll_btn high produces exactly one roll.
- win and lose are never both 1.
- Reset mid-roll aborts immediately to the reset values.

Optional Feature:
- Macro: CRAPS_ROLL_COUNT_EN.
- Defined: adds output roll_count [7:0].
  - Increments by 1 on every legal EVAL, saturating at 255.
  - Cleared on reset and on the WIN/LOSE -> COME_OUT transition.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then come-out roll, ROLL_CYCLES=4, dice 3+4 at EVAL -> roll_en high exactly 4 cycles; disp_en high 5 cycles; WIN with win=1, point=0.
- Come-out dice 1+1 -> LOSE, lose=1. Then a roll_btn rise -> COME_OUT with win=lose=0 and no roll_en pulse.
- Come-out 2+4 -> POINT with point=6. Next roll 5+3 -> POINT, point=6. Next roll 1+5 -> WIN.
- Point phase, point=8, roll 3+4 -> LOSE, lose=1, point stays 8.
- Dice1=7 at EVAL -> roll_en reasserts for another ROLL_CYCLES, no score change. Separately: holding roll_btn high for 50 cycles produces a single roll; a press during ROLLING is ignored.
- resetn pulsed low mid-ROLLING -> all outputs 0 asynchronously, state COME_OUT. With CRAPS_ROLL_COUNT_EN defined, roll_count=3 after three legal rolls.
